// File: rtl/ad4003_acq_controller.sv
// Frame sequencer for an AD4003 front end: configures the converter, verifies the
// register readback, then runs fixed-period acquisition frames for the deserializer.
`timescale 1ns/1ps

module ad4003_acq_controller #(
  parameter int CONV_PERIOD = 100,
  parameter int SYNC_LEN    = 4,
  parameter int START_OFS   = 6,
  parameter int START_LEN   = 30,
  parameter int DONE_OFS    = 40,
  parameter int RETRY_MAX   = 3
) (
  input  logic        clk_100,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        adc_config_status,
  output logic        word_sync_n,
  output logic        adc_start_conv,
  output logic [1:0]  mode,
  output logic        sample_valid,
  output logic [31:0] sample_cnt,
  output logic        cfg_done,
  output logic        cfg_fault
);

  localparam int FC_W    = (CONV_PERIOD > 1) ? $clog2(CONV_PERIOD) : 1;
  localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  localparam logic [FC_W-1:0]    FC_LAST   = FC_W'(CONV_PERIOD - 1);
  localparam logic [FC_W-1:0]    SYNC_END  = FC_W'(SYNC_LEN);
  localparam logic [FC_W-1:0]    START_BEG = FC_W'(START_OFS);
  localparam logic [FC_W-1:0]    START_END = FC_W'(START_OFS + START_LEN);
  localparam logic [FC_W-1:0]    DONE_AT   = FC_W'(DONE_OFS);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_WR,
    ST_CFG_RD,
    ST_CFG_CHK,
    ST_ACQUIRE,
    ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    MODE_IDLE    = 2'd0,
    MODE_ACQUIRE = 2'd1,
    MODE_REG_WR  = 2'd2,
    MODE_REG_RD  = 2'd3
  } mode_t;

  state_t               state, state_d;
  logic [FC_W-1:0]      fc, fc_d;
  logic [RETRY_W-1:0]   retry, retry_d;
  logic [1:0]           sync_ff;
  logic                 status_sync;
  logic                 stop_req, stop_d;
  logic                 wrap;
  logic                 word_sync_n_d, adc_start_conv_d, sample_valid_d;
  logic                 cfg_done_d, cfg_fault_d;
  mode_t                mode_d;
  logic [31:0]          sample_cnt_d;

  assign status_sync = sync_ff[1];
  assign wrap        = (state != ST_IDLE) && (fc == FC_LAST);

  // Two-flop synchronizer for the deserializer's status flag.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= 2'b00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync_ff <= {sync_ff[0], adc_config_status};
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d     = state;
    retry_d     = retry;
    cfg_done_d  = cfg_done;
    cfg_fault_d = cfg_fault;
    stop_d      = stop_req | ((state != ST_IDLE) & ~enable);

    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_d     = ST_CFG_WR;
          retry_d     = '0;
          cfg_done_d  = 1'b0;
          cfg_fault_d = 1'b0;
        end
      end
      ST_CFG_WR: if (wrap) state_d = ST_CFG_RD;
      ST_CFG_RD: if (wrap) state_d = ST_CFG_CHK;
      ST_CFG_CHK: begin
        // The verdict is latched mid-frame; the state only moves at the wrap.
        if (fc == DONE_AT) begin
          if (status_sync) cfg_done_d = 1'b1;
          else             retry_d    = retry + 1'b1;
        end
        if (wrap) begin
          if (cfg_done)               state_d = ST_ACQUIRE;
          else if (retry < RETRY_LIM) state_d = ST_CFG_WR;
          else begin
            state_d     = ST_FAULT;
            cfg_fault_d = 1'b1;
          end
        end
      end
      ST_ACQUIRE: state_d = ST_ACQUIRE;
      ST_FAULT:   state_d = ST_FAULT;
      default:    state_d = ST_IDLE;
    endcase

    // A stop request, even if enable has since come back, wins at the frame boundary.
    if (wrap && stop_d) begin
      state_d     = ST_IDLE;
      cfg_fault_d = cfg_fault;
    end
    if (state_d == ST_IDLE) stop_d = 1'b0;

    fc_d = ((state == ST_IDLE) || wrap) ? '0 : fc + 1'b1;

    // Outputs are decoded from next-cycle state so they leave the flops glitch-free.
    word_sync_n_d    = !((state_d != ST_IDLE) && (fc_d < SYNC_END));
    adc_start_conv_d = (state_d != ST_IDLE) && (state_d != ST_FAULT) &&
                       (fc_d >= START_BEG) && (fc_d < START_END);
    sample_valid_d   = (state_d == ST_ACQUIRE) && (fc_d == DONE_AT);
    sample_cnt_d     = sample_valid_d ? sample_cnt + 32'd1 : sample_cnt;

    case (state_d)
      ST_CFG_WR:  mode_d = MODE_REG_WR;
      ST_CFG_RD:  mode_d = MODE_REG_RD;
      ST_CFG_CHK: mode_d = MODE_REG_RD;
      ST_ACQUIRE: mode_d = MODE_ACQUIRE;
      default:    mode_d = MODE_IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: only control flops exist here; every one is reset so outputs are defined out of reset.
      state          <= ST_IDLE;
      fc             <= '0;
      retry          <= '0;
      stop_req       <= 1'b0;
      word_sync_n    <= 1'b1;
      adc_start_conv <= 1'b0;
      mode           <= MODE_IDLE;
      sample_valid   <= 1'b0;
      sample_cnt     <= '0;
      cfg_done       <= 1'b0;
      cfg_fault      <= 1'b0;
    end else begin
      state          <= state_d;
      fc             <= fc_d;
      retry          <= retry_d;
      stop_req       <= stop_d;
      word_sync_n    <= word_sync_n_d;
      adc_start_conv <= adc_start_conv_d;
      mode           <= mode_d;
      sample_valid   <= sample_valid_d;
      sample_cnt     <= sample_cnt_d;
      cfg_done       <= cfg_done_d;
      cfg_fault      <= cfg_fault_d;
    end
  end

endmodule

// File: tb/tb_ad4003_acq_controller.sv
// Directed bench for ad4003_acq_controller: cycle-by-cycle timeline expectations
// for configuration, retry, fault, stop and asynchronous reset scenarios.
`timescale 1ns/1ps

module tb_ad4003_acq_controller;

  logic        clk_100 = 1'b0;
  logic        rst_n   = 1'b0;
  logic        enable  = 1'b0;
  logic        adc_config_status = 1'b0;
  logic        word_sync_n;
  logic        adc_start_conv;
  logic [1:0]  mode;
  logic        sample_valid;
  logic [31:0] sample_cnt;
  logic        cfg_done;
  logic        cfg_fault;

  int checks = 0;
  int errors = 0;

  logic [6:0] obs;
  assign obs = {mode, word_sync_n, adc_start_conv, sample_valid, cfg_done, cfg_fault};

  ad4003_acq_controller dut (
    .clk_100           (clk_100),
    .rst_n             (rst_n),
    .enable            (enable),
    .adc_config_status (adc_config_status),
    .word_sync_n       (word_sync_n),
    .adc_start_conv    (adc_start_conv),
    .mode              (mode),
    .sample_valid      (sample_valid),
    .sample_cnt        (sample_cnt),
    .cfg_done          (cfg_done),
    .cfg_fault         (cfg_fault)
  );

  always #5 clk_100 = ~clk_100;

  // Frame-level monitor: mode steady under adc_start_conv, sync pulse exactly 4 wide.
  logic [1:0] prev_mode = 2'd0;
  logic       prev_start = 1'b0;
  int         low_cnt = 0;

  always @(negedge clk_100) begin
    if (!rst_n) begin
      low_cnt = 0;
    end else begin
      if (adc_start_conv && prev_start) begin
        checks++;
        if (mode !== prev_mode) begin
          errors++;
          $display("FAIL mode_stable t=%0t mode=%0d was=%0d while adc_start_conv=1", $time, mode, prev_mode);
        end
      end
      if (!word_sync_n) begin
        low_cnt++;
      end else if (low_cnt != 0) begin
        checks++;
        if (low_cnt != 4) begin
          errors++;
          $display("FAIL sync_width t=%0t got=%0d exp=4", $time, low_cnt);
        end
        low_cnt = 0;
      end
    end
    prev_mode  = mode;
    prev_start = adc_start_conv;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_100);
    #1;
  endtask

  task automatic apply_reset();
    enable = 1'b0;
    rst_n  = 1'b0;
    step(3);
    rst_n  = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    adc_config_status = 1'b1;
    step(3);
    checks++;
    if (obs !== 7'b00_1_0_0_0_0 || sample_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got=%b/%0d exp=0010000/0", obs, sample_cnt);
    end
    enable = 1'b0;
    rst_n  = 1'b1;
    step(5);
    checks++;
    if (obs !== 7'b00_1_0_0_0_0 || sample_cnt !== 32'd0) begin
      errors++;
      $display("FAIL idle_no_enable got=%b/%0d exp=0010000/0", obs, sample_cnt);
    end
  endtask

  task automatic test_config_pass();
    int fc, fr;
    logic [1:0] em;
    logic ews, esc, esv, edone;
    logic [31:0] ecnt;
    adc_config_status = 1'b1;
    apply_reset();
    enable = 1'b1;
    ecnt = 0;
    for (int k = 1; k <= 550; k++) begin
      step(1);
      fc = (k - 1) % 100;
      fr = (k - 1) / 100;
      em = (fr == 0) ? 2'd2 : (fr < 3) ? 2'd3 : 2'd1;
      ews = !(fc < 4);
      esc = (fc >= 6) && (fc < 36);
      esv = (fr >= 3) && (fc == 40);
      edone = (k >= 242);
      if (esv) ecnt++;
      checks++;
      if (obs !== {em, ews, esc, esv, edone, 1'b0} || sample_cnt !== ecnt) begin
        errors++;
        $display("FAIL cfg_pass k=%0d got=%b/%0d exp=%b/%0d", k, obs, sample_cnt,
                 {em, ews, esc, esv, edone, 1'b0}, ecnt);
      end
    end
  endtask

  task automatic test_config_fault();
    int fc, fr;
    logic [1:0] em;
    logic ews, esc, efault;
    adc_config_status = 1'b0;
    apply_reset();
    enable = 1'b1;
    for (int k = 1; k <= 950; k++) begin
      step(1);
      fc = (k - 1) % 100;
      fr = (k - 1) / 100;
      em = (fr >= 9) ? 2'd0 : ((fr % 3) == 0) ? 2'd2 : 2'd3;
      ews = !(fc < 4);
      esc = (fr < 9) && (fc >= 6) && (fc < 36);
      efault = (k >= 901);
      checks++;
      if (obs !== {em, ews, esc, 1'b0, 1'b0, efault} || sample_cnt !== 32'd0) begin
        errors++;
        $display("FAIL cfg_fault k=%0d got=%b/%0d exp=%b/0", k, obs, sample_cnt,
                 {em, ews, esc, 1'b0, 1'b0, efault});
      end
    end
  endtask

  task automatic test_retry_pass();
    int fc, fr;
    logic [1:0] em;
    logic ews, esc, esv, edone;
    logic [31:0] ecnt;
    adc_config_status = 1'b0;
    apply_reset();
    enable = 1'b1;
    ecnt = 0;
    for (int k = 1; k <= 650; k++) begin
      step(1);
      fc = (k - 1) % 100;
      fr = (k - 1) / 100;
      em = (fr >= 6) ? 2'd1 : ((fr % 3) == 0) ? 2'd2 : 2'd3;
      ews = !(fc < 4);
      esc = (fc >= 6) && (fc < 36);
      esv = (fr >= 6) && (fc == 40);
      edone = (k >= 542);
      if (esv) ecnt++;
      checks++;
      if (obs !== {em, ews, esc, esv, edone, 1'b0} || sample_cnt !== ecnt) begin
        errors++;
        $display("FAIL retry_pass k=%0d got=%b/%0d exp=%b/%0d", k, obs, sample_cnt,
                 {em, ews, esc, esv, edone, 1'b0}, ecnt);
      end
      if (k == 300) adc_config_status = 1'b1;
    end
  endtask

  task automatic test_enable_drop();
    int fc, fr;
    logic [1:0] em;
    logic ews, esc, esv;
    logic [31:0] ecnt;
    logic [6:0] ev;
    adc_config_status = 1'b1;
    apply_reset();
    enable = 1'b1;
    ecnt = 0;
    for (int k = 1; k <= 600; k++) begin
      step(1);
      fc = (k - 1) % 100;
      fr = (k - 1) / 100;
      if (k >= 401) begin
        ev = {2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      end else begin
        em = (fr == 0) ? 2'd2 : (fr < 3) ? 2'd3 : 2'd1;
        ews = !(fc < 4);
        esc = (fc >= 6) && (fc < 36);
        esv = (fr >= 3) && (fc == 40);
        if (esv) ecnt++;
        ev = {em, ews, esc, esv, (k >= 242), 1'b0};
      end
      checks++;
      if (obs !== ev || sample_cnt !== ecnt) begin
        errors++;
        $display("FAIL enable_drop k=%0d got=%b/%0d exp=%b/%0d", k, obs, sample_cnt, ev, ecnt);
      end
      if (k == 351) enable = 1'b0;
    end
    // Restart from IDLE, then drop and re-raise enable inside one frame.
    enable = 1'b1;
    for (int k = 1; k <= 105; k++) begin
      step(1);
      if (k <= 100) begin
        fc = k - 1;
        ev = {2'd2, !(fc < 4), (fc >= 6) && (fc < 36), 1'b0, 1'b0, 1'b0};
      end else if (k == 101) begin
        ev = {2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      end else begin
        fc = k - 102;
        ev = {2'd2, !(fc < 4), (fc >= 6) && (fc < 36), 1'b0, 1'b0, 1'b0};
      end
      checks++;
      if (obs !== ev || sample_cnt !== 32'd1) begin
        errors++;
        $display("FAIL reenable k=%0d got=%b/%0d exp=%b/1", k, obs, sample_cnt, ev);
      end
      if (k == 50) enable = 1'b0;
      if (k == 60) enable = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    int fc, fr;
    logic [1:0] em;
    logic ews, esc, esv, edone;
    logic [31:0] ecnt;
    adc_config_status = 1'b1;
    apply_reset();
    enable = 1'b1;
    ecnt = 0;
    for (int k = 1; k <= 411; k++) begin
      step(1);
      fc = (k - 1) % 100;
      fr = (k - 1) / 100;
      em = (fr == 0) ? 2'd2 : (fr < 3) ? 2'd3 : 2'd1;
      esv = (fr >= 3) && (fc == 40);
      if (esv) ecnt++;
      checks++;
      if (obs !== {em, !(fc < 4), (fc >= 6) && (fc < 36), esv, (k >= 242), 1'b0} ||
          sample_cnt !== ecnt) begin
        errors++;
        $display("FAIL pre_reset k=%0d got=%b/%0d exp_cnt=%0d", k, obs, sample_cnt, ecnt);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b00_1_0_0_0_0 || sample_cnt !== 32'd0) begin
      errors++;
      $display("FAIL async_reset got=%b/%0d exp=0010000/0", obs, sample_cnt);
    end
    step(2);
    rst_n = 1'b1;
    ecnt = 0;
    for (int k = 1; k <= 350; k++) begin
      step(1);
      fc = (k - 1) % 100;
      fr = (k - 1) / 100;
      em = (fr == 0) ? 2'd2 : (fr < 3) ? 2'd3 : 2'd1;
      ews = !(fc < 4);
      esc = (fc >= 6) && (fc < 36);
      esv = (fr >= 3) && (fc == 40);
      edone = (k >= 242);
      if (esv) ecnt++;
      checks++;
      if (obs !== {em, ews, esc, esv, edone, 1'b0} || sample_cnt !== ecnt) begin
        errors++;
        $display("FAIL post_reset k=%0d got=%b/%0d exp=%b/%0d", k, obs, sample_cnt,
                 {em, ews, esc, esv, edone, 1'b0}, ecnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_config_pass();
    test_config_fault();
    test_retry_pass();
    test_enable_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad4003_acq_controller.md
AD4003_ACQ_CONTROLLER -- requirements
Module: ad4003_acq_controller

Interface
REQ-001 SHALL have parameter CONV_PERIOD, default 100, clk_100 cycles per conversion frame (1 MSPS).
REQ-002 SHALL have parameter SYNC_LEN, default 4, cycles word_sync_n is held low at frame start.
REQ-003 SHALL have parameter START_OFS, default 6, frame cycle at which adc_start_conv rises.
REQ-004 SHALL have parameter START_LEN, default 30, cycles adc_start_conv is held high.
REQ-005 SHALL have parameter DONE_OFS, default 40, frame cycle at which the frame result is taken.
REQ-006 SHALL have parameter RETRY_MAX, default 3, number of configuration attempts before fault.
REQ-007 SHALL have port clk_100, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port enable, input, 1, run request (synchronous to clk_100).
REQ-010 SHALL have port adc_config_status, input, 1, deserializer register-OK flag from another clock domain.
REQ-011 SHALL have port word_sync_n, output, 1, frame-start marker, active low.
REQ-012 SHALL have port adc_start_conv, output, 1, conversion/readout window to the deserializer.
REQ-013 SHALL have port mode, output, 2, 0 idle, 1 acquire, 2 register write, 3 register read.
REQ-014 SHALL have port sample_valid, output, 1, one-cycle strobe: acquire-frame data stable.
REQ-015 SHALL have port sample_cnt, output, 32, count of sample_valid strobes.
REQ-016 SHALL have port cfg_done, output, 1, ADC configuration verified.
REQ-017 SHALL have port cfg_fault, output, 1, configuration failed RETRY_MAX times.

Function
REQ-018 SHALL keep frame counter fc, 0..CONV_PERIOD-1, wrapping to 0; it runs only in non-IDLE states and is held at 0 in IDLE.
REQ-019 SHALL drive word_sync_n low when fc < SYNC_LEN and the state is not IDLE, high otherwise.
REQ-020 SHALL drive adc_start_conv high when START_OFS <= fc < START_OFS+START_LEN and the state is not IDLE or FAULT.
REQ-021 SHALL change mode only when fc==0, so that mode is stable before the adc_start_conv rising edge.
REQ-022 SHALL pass adc_config_status through a two-flop synchronizer before use.
REQ-023 SHALL implement states IDLE, CFG_WR (mode 2), CFG_RD (mode 3), CFG_CHK (mode 3), ACQUIRE (mode 1), and FAULT (mode 0); every transition out of a non-IDLE state occurs at a frame wrap.
REQ-024 SHALL transition IDLE->CFG_WR when enable=1, clearing the retry count, cfg_done and cfg_fault; the frame starts at fc=0 on the next cycle.
REQ-025 SHALL run CFG_WR for exactly one frame, then CFG_RD for one frame, then CFG_CHK for one frame.
REQ-026 SHALL sample the synchronized status at fc==DONE_OFS of CFG_CHK: 1 -> ACQUIRE with cfg_done=1; 0 -> retry+1, then CFG_WR if retry<RETRY_MAX, else FAULT with cfg_fault=1.
REQ-027 SHALL, in ACQUIRE, pulse sample_valid for one cycle at fc==DONE_OFS, increment sample_cnt with modulo-2^32 wrap, and never pulse sample_valid in any other state.
REQ-028 SHALL, when enable=0 in any non-IDLE state, complete the current frame and enter IDLE at the wrap; cfg_done and cfg_fault hold their values until the next start.
REQ-029 SHALL, in FAULT, keep word_sync_n framing with adc_start_conv low, and leave FAULT only via enable=0.
REQ-030 SHALL ignore enable re-assertion in the same frame in which it was dropped; the IDLE exit occurs no earlier than one cycle after IDLE entry.
REQ-031 SHALL tolerate parameter legality SYNC_LEN<START_OFS, START_OFS+START_LEN<DONE_OFS<CONV_PERIOD; the behaviour is undefined otherwise.

Reset
REQ-032 SHALL, while rst_n=0, force state IDLE, fc=0, word_sync_n=1, adc_start_conv=0, mode=0, sample_valid=0, sample_cnt=0, cfg_done=0, cfg_fault=0, retry=0, synchronizer=0.
REQ-033 SHALL, on reset asserted mid-frame, drop adc_start_conv and raise word_sync_n immediately (asynchronously).

Verification
REQ-034 Bench SHALL cover: enable=1, status=1 -> frames with mode 2,3,3 then 1; cfg_done=1 at cycle 2*100+40+2 (after the synchronizer); sample_valid every 100 cycles.
REQ-035 Bench SHALL cover: status=0 always -> three WR/RD/CHK sequences (900 cycles), then cfg_fault=1, mode=0, adc_start_conv stays low.
REQ-036 Bench SHALL cover: status=0 for the first attempt and 1 for the second -> ACQUIRE entered after 6 frames with cfg_fault=0.
REQ-037 Bench SHALL cover: enable dropped at fc=50 in ACQUIRE -> that frame's sample_valid is already counted, IDLE at the wrap, no further pulses, and sample_cnt is held.
REQ-038 Bench SHALL cover: rst_n pulsed low at fc=10 in ACQUIRE -> adc_start_conv=0 within the same cycle, sample_cnt=0, and the full config sequence restarts after release.
REQ-039 Bench SHALL check on every frame that mode never changes while adc_start_conv=1, and that the word_sync_n low width is exactly 4 cycles.
